// File: rtl/nss_pkg.sv
// Shared types and constants for the nibble-serial subtractor.
// SUB_OVF_EN (optional) adds the signed-overflow output.
package nss_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int NIBBLE = 4;

  function automatic int nibbles(input int width);
    return width / NIBBLE;
  endfunction

endpackage

// File: rtl/nibble_serial_subtractor_borrow_lookahead4.sv
// Combinational 4-bit subtract cell with borrow lookahead.
// Each borrow is a flat generate/propagate term, not a ripple.
module borrow_lookahead4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       bi,
  output logic [3:0] d,
  output logic       bo
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] bw;

  assign g = ~x & y;
  assign p = ~(x ^ y);

  assign bw[0] = bi;
  assign bw[1] = g[0] | (p[0] & bi);
  assign bw[2] = g[1] | (p[1] & g[0])
               | (p[1] & p[0] & bi);
  assign bw[3] = g[2] | (p[2] & g[1])
               | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & bi);
  assign bo    = g[3] | (p[3] & g[2])
               | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & bi);

  assign d = x ^ y ^ bw;

endmodule

// File: rtl/nibble_serial_subtractor.sv
// diff = a - b - bin, one nibble per clock, LSB nibble first.
// Define SUB_OVF_EN to add the ovf port and its logic.
module nibble_serial_subtractor
  import nss_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N  = nibbles(WIDTH);
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  state_e           state_q;
  logic [KW-1:0]    k_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] diff_q;
  logic [WIDTH-1:0] diff_d;
  logic             br_q;
  logic             busy_q;
  logic             done_q;
  logic             bout_q;
  logic             last;

  logic [WIDTH-1:0]  a_sh;
  logic [WIDTH-1:0]  b_sh;
  logic [NIBBLE-1:0] x_nib;
  logic [NIBBLE-1:0] y_nib;
  logic [NIBBLE-1:0] d_nib;
  logic              bo_nib;

  // One shared cell; the counter steers operand nibbles into it.
  assign a_sh  = a_q >> (int'(k_q) * NIBBLE);
  assign b_sh  = b_q >> (int'(k_q) * NIBBLE);
  assign x_nib = a_sh[NIBBLE-1:0];
  assign y_nib = b_sh[NIBBLE-1:0];
  assign last  = (k_q == KW'(N - 1));

  borrow_lookahead4 u_cell (
    .x  (x_nib),
    .y  (y_nib),
    .bi (br_q),
    .d  (d_nib),
    .bo (bo_nib)
  );

  always_comb begin
    diff_d = diff_q;
    for (int i = 0; i < N; i++) begin
      if (k_q == KW'(i)) begin
        diff_d[i*NIBBLE +: NIBBLE] = d_nib;
      end
    end
  end

`ifdef SUB_OVF_EN
  logic ovf_q;
  assign ovf = ovf_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      br_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bout_q  <= 1'b0;
`ifdef SUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            br_q    <= bin;
            k_q     <= '0;
            diff_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          diff_q <= diff_d;
          br_q   <= bo_nib;
          k_q    <= k_q + KW'(1);
          if (last) begin
            bout_q  <= bo_nib;
`ifdef SUB_OVF_EN
            ovf_q   <= (a_q[WIDTH-1] ^ b_q[WIDTH-1])
                     & (d_nib[NIBBLE-1] ^ a_q[WIDTH-1]);
`endif
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Scoreboard bench: driver queues expected results, monitor checks.
// Build with SUB_OVF_EN to also check ovf.
module tb_nibble_serial_subtractor;

  localparam int W = 16;
  localparam int N = W / 4;

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    int           due;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SUB_OVF_EN
  logic         ovf;
`endif

  int   checks;
  int   errors;
  int   ncyc;
  int   ndone;
  exp_t q[$];

  nibble_serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               name, act, exp, $time);
    end
  endtask

  // Reference: plain (W+1)-bit arithmetic plus the signed-overflow rule.
  function automatic exp_t model(input logic [W-1:0] ma,
                                 input logic [W-1:0] mb,
                                 input logic         mbin);
    exp_t e;
    logic [W:0] r;
    r = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
    e.diff = r[W-1:0];
    e.bout = r[W];
    e.ovf  = (ma[W-1] != mb[W-1]) && (r[W-1] != ma[W-1]);
    e.due  = 0;
    return e;
  endfunction

  // Raises start for exactly one accepting edge.
  task automatic issue(input logic [W-1:0] ia,
                       input logic [W-1:0] ib,
                       input logic         ibin);
    exp_t e;
    @(negedge clk);
    #1;
    a = ia;
    b = ib;
    bin = ibin;
    start = 1'b1;
    e = model(ia, ib, ibin);
    e.due = ncyc + N + 1;
    q.push_back(e);
    @(negedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    bin = 1'($urandom);
  endtask

  always @(negedge clk) begin
    exp_t f;
    ncyc++;
    if (rst_n) begin
      check("busy_done_excl", 64'(busy & done), 64'(0));
      if (q.size() > 0) begin
        check("busy", 64'(busy),
              64'(ncyc >= q[0].due - N && ncyc < q[0].due));
      end else begin
        check("busy_idle", 64'(busy), 64'(0));
      end
      if (done) begin
        ndone++;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_done: done=1 expected 0 @%0t", $time);
        end else begin
          f = q.pop_front();
          check("done_time", 64'(ncyc), 64'(f.due));
          check("diff", 64'(diff), 64'(f.diff));
          check("bout", 64'(bout), 64'(f.bout));
`ifdef SUB_OVF_EN
          check("ovf", 64'(ovf), 64'(f.ovf));
`endif
        end
      end else if (q.size() > 0 && ncyc >= q[0].due) begin
        f = q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_done: done=0 expected 1 @%0t", $time);
      end
    end
  end

  initial begin
    int d0;
    checks = 0;
    errors = 0;
    ncyc   = 0;
    ndone  = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    bin    = 1'b0;
    #3;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_diff", 64'(diff), 64'(0));
    check("rst_bout", 64'(bout), 64'(0));
`ifdef SUB_OVF_EN
    check("rst_ovf", 64'(ovf), 64'(0));
`endif
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;

    issue(16'h1234, 16'h0034, 1'b0);
    repeat (N + 2) @(negedge clk);
    issue(16'h0000, 16'h0001, 1'b0);
    repeat (N + 2) @(negedge clk);
    issue(16'h0000, 16'h0000, 1'b1);
    repeat (N + 2) @(negedge clk);
    issue(16'h8000, 16'h0000, 1'b1);
    repeat (N + 2) @(negedge clk);
    issue(16'h7FFF, 16'hFFFF, 1'b0);
    repeat (N + 2) @(negedge clk);

    // Start pulse in the 2nd RUN cycle must be ignored.
    d0 = ndone;
    issue(16'hA5A5, 16'h5A5A, 1'b1);
    #1;
    a = 16'h0001;
    b = 16'h0002;
    bin = 1'b0;
    start = 1'b1;
    @(negedge clk);
    #1;
    start = 1'b0;
    repeat (N + 2) @(negedge clk);
    check("one_done", 64'(ndone - d0), 64'(1));

    // Reset in the 3rd RUN cycle aborts with no done pulse.
    d0 = ndone;
    issue(16'h4321, 16'h1234, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b0;
    q.delete();
    #1;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    check("abort_diff", 64'(diff), 64'(0));
    check("abort_bout", 64'(bout), 64'(0));
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (N + 2) @(negedge clk);
    check("abort_no_done", 64'(ndone - d0), 64'(0));
    issue(16'hBEEF, 16'h1111, 1'b1);
    repeat (N + 2) @(negedge clk);

    // Back-to-back: second start lands in the done cycle.
    issue(16'h1000, 16'h0001, 1'b0);
    repeat (N - 1) @(negedge clk);
    issue(16'hFFFF, 16'h0001, 1'b0);
    repeat (N + 2) @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 0) begin
        repeat (N - 1) @(negedge clk);
      end else begin
        repeat (N + $urandom_range(0, 3)) @(negedge clk);
      end
    end
    repeat (N + 4) @(negedge clk);
    check("queue_empty", 64'(q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
